// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Function : Multi-cycle, word-addressed 16-bit data memory. It accepts a
//            load or store from the memory stage, stalls the pipeline for a
//            fixed latency, then pulses MemDone with the read data registered.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemR,
   input  logic        MemW,
   input  logic [15:0] Address,
   input  logic [15:0] DataIn,
   output logic [15:0] MemoryOut,
   output logic        Stall,
   output logic        MemDone,
   output logic        ReqErr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;
   logic [15:0]         mo_q;
   logic [15:0]         mem_q [DEPTH];
   logic                w_complete;
   logic                w_unused_addr;

   // Upper address bits are deliberately dropped so addresses alias modulo DEPTH.
   assign w_unused_addr = ^Address[15:ADDR_W];

   // Next-state, request capture and stall decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      err_d   = err_q;
      Stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemR || MemW) begin
               // Stall is gated by reset so it stays low while reset is held.
               Stall   = reset;
               idx_d   = Address[ADDR_W-1:0];
               wdata_d = DataIn;
               wr_d    = MemW;
               err_d   = MemR & MemW;
               if (LATENCY == 1) begin
                  state_d = S_DONE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = c_lat_m1;
               end
            end
         end
         S_BUSY: begin
            Stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // The access completes on the edge that enters DONE; the *_d values equal the
   // captured request there (or the live request when IDLE goes straight to DONE).
   assign w_complete = reset && (state_q != S_DONE) && (state_d == S_DONE);

   // State, latency counter and captured request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // Storage array; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (w_complete && wr_d) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

   // Read data register: only a completing read updates it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mo_q <= 16'h0000;
      end else if (w_complete && !wr_d) begin
         mo_q <= mem_q[idx_d];
      end
   end

   assign MemoryOut = mo_q;
   assign MemDone   = (state_q == S_DONE);
   assign ReqErr    = (state_q == S_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Function : Self-checking bench for data_mem_responder at LATENCY 2, 1 and 3
//            using per-cycle directed vectors with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   typedef struct {
      int          k;
      logic        rst;
      logic        r;
      logic        w;
      logic [15:0] addr;
      logic [15:0] din;
      logic        st;
      logic        dn;
      logic        er;
      logic [15:0] mo;
   } vec_t;

   logic              clk;
   logic [2:0]        rst_n;
   logic [2:0]        mr;
   logic [2:0]        mw;
   logic [2:0][15:0]  addr;
   logic [2:0][15:0]  din;
   logic [15:0]       mo0, mo1, mo2;
   logic              st0, st1, st2;
   logic              dn0, dn1, dn2;
   logic              er0, er1, er2;

   int                n_tests;
   int                n_fail;
   vec_t              tbl[$];

   data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .reset(rst_n[0]), .MemR(mr[0]), .MemW(mw[0]),
      .Address(addr[0]), .DataIn(din[0]), .MemoryOut(mo0),
      .Stall(st0), .MemDone(dn0), .ReqErr(er0));

   data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(rst_n[1]), .MemR(mr[1]), .MemW(mw[1]),
      .Address(addr[1]), .DataIn(din[1]), .MemoryOut(mo1),
      .Stall(st1), .MemDone(dn1), .ReqErr(er1));

   data_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset(rst_n[2]), .MemR(mr[2]), .MemW(mw[2]),
      .Address(addr[2]), .DataIn(din[2]), .MemoryOut(mo2),
      .Stall(st2), .MemDone(dn2), .ReqErr(er2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int k, input logic rst, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic st, input logic dn, input logic er,
                      input logic [15:0] mo);
      vec_t v;
      v.k = k; v.rst = rst; v.r = r; v.w = w; v.addr = a; v.din = d;
      v.st = st; v.dn = dn; v.er = er; v.mo = mo;
      tbl.push_back(v);
   endtask

   task automatic chk1(input string name, input int row, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
      end
   endtask

   task automatic chk16(input string name, input int row, input logic [15:0] act,
                        input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      logic        a_st, a_dn, a_er;
      logic [15:0] a_mo;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 3'b000;
      mr      = 3'b000;
      mw      = 3'b000;
      addr    = '0;
      din     = '0;

      // ---- LATENCY=2: reset, write/read, wrap, conflict ----
      //      k rst R  W  addr      din       st dn er mo
      add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(0, 1, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000);
      add(0, 1, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000);
      add(0, 1, 0, 1, 16'h0010, 16'hBEEF, 0, 1, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000);
      add(0, 1, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'hBEEF);
      add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);
      add(0, 1, 0, 1, 16'h0105, 16'hA5A5, 1, 0, 0, 16'hBEEF);
      add(0, 1, 0, 1, 16'h0105, 16'hA5A5, 1, 0, 0, 16'hBEEF);
      add(0, 1, 0, 1, 16'h0105, 16'hA5A5, 0, 1, 0, 16'hBEEF);
      add(0, 1, 1, 0, 16'h0005, 16'h0000, 1, 0, 0, 16'hBEEF);
      add(0, 1, 1, 0, 16'h0005, 16'h0000, 1, 0, 0, 16'hBEEF);
      add(0, 1, 1, 0, 16'h0005, 16'h0000, 0, 1, 0, 16'hA5A5);
      add(0, 1, 0, 1, 16'h0020, 16'h1111, 1, 0, 0, 16'hA5A5);
      add(0, 1, 0, 1, 16'h0020, 16'h1111, 1, 0, 0, 16'hA5A5);
      add(0, 1, 0, 1, 16'h0020, 16'h1111, 0, 1, 0, 16'hA5A5);
      add(0, 1, 1, 0, 16'h0020, 16'h0000, 1, 0, 0, 16'hA5A5);
      add(0, 1, 1, 0, 16'h0020, 16'h0000, 1, 0, 0, 16'hA5A5);
      add(0, 1, 1, 0, 16'h0020, 16'h0000, 0, 1, 0, 16'h1111);
      add(0, 1, 1, 1, 16'h0007, 16'h00FF, 1, 0, 0, 16'h1111);
      add(0, 1, 1, 1, 16'h0007, 16'h00FF, 1, 0, 0, 16'h1111);
      add(0, 1, 1, 1, 16'h0007, 16'h00FF, 0, 1, 1, 16'h1111);
      add(0, 1, 1, 0, 16'h0007, 16'h0000, 1, 0, 0, 16'h1111);
      add(0, 1, 1, 0, 16'h0007, 16'h0000, 1, 0, 0, 16'h1111);
      add(0, 1, 1, 0, 16'h0007, 16'h0000, 0, 1, 0, 16'h00FF);
      add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h00FF);

      // ---- LATENCY=1: back-to-back accesses held through the handshake ----
      add(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(1, 1, 0, 1, 16'h0003, 16'h1234, 1, 0, 0, 16'h0000);
      add(1, 1, 0, 1, 16'h0003, 16'h1234, 0, 1, 0, 16'h0000);
      add(1, 1, 0, 1, 16'h0004, 16'h5678, 1, 0, 0, 16'h0000);
      add(1, 1, 0, 1, 16'h0004, 16'h5678, 0, 1, 0, 16'h0000);
      add(1, 1, 1, 0, 16'h0003, 16'h0000, 1, 0, 0, 16'h0000);
      add(1, 1, 1, 0, 16'h0003, 16'h0000, 0, 1, 0, 16'h1234);
      add(1, 1, 1, 0, 16'h0004, 16'h0000, 1, 0, 0, 16'h1234);
      add(1, 1, 1, 0, 16'h0004, 16'h0000, 0, 1, 0, 16'h5678);
      add(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5678);

      // ---- LATENCY=3: reset in the middle of a write aborts it ----
      add(2, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'h1357, 1, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'h1357, 1, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'h1357, 1, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'h1357, 0, 1, 0, 16'h0000);
      add(2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'hCAFE, 1, 0, 0, 16'h0000);
      add(2, 1, 0, 1, 16'h0009, 16'hCAFE, 1, 0, 0, 16'h0000);
      add(2, 0, 0, 1, 16'h0009, 16'hCAFE, 0, 0, 0, 16'h0000);
      add(2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
      add(2, 1, 1, 0, 16'h0009, 16'h0000, 1, 0, 0, 16'h0000);
      add(2, 1, 1, 0, 16'h0009, 16'h0000, 1, 0, 0, 16'h0000);
      add(2, 1, 1, 0, 16'h0009, 16'h0000, 1, 0, 0, 16'h0000);
      add(2, 1, 1, 0, 16'h0009, 16'h0000, 0, 1, 0, 16'h1357);
      add(2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h1357);

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         rst_n[tbl[i].k] = tbl[i].rst;
         mr[tbl[i].k]    = tbl[i].r;
         mw[tbl[i].k]    = tbl[i].w;
         addr[tbl[i].k]  = tbl[i].addr;
         din[tbl[i].k]   = tbl[i].din;
         @(negedge clk);
         case (tbl[i].k)
            0:       begin a_st = st0; a_dn = dn0; a_er = er0; a_mo = mo0; end
            1:       begin a_st = st1; a_dn = dn1; a_er = er1; a_mo = mo1; end
            default: begin a_st = st2; a_dn = dn2; a_er = er2; a_mo = mo2; end
         endcase
         chk1 ("Stall",     i, a_st, tbl[i].st);
         chk1 ("MemDone",   i, a_dn, tbl[i].dn);
         chk1 ("ReqErr",    i, a_er, tbl[i].er);
         chk16("MemoryOut", i, a_mo, tbl[i].mo);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
